ofm_buf_ctrl: RTL and testbench

Sequencer for the output-feature-map stripe buffer (`fifo_ofm`, byte-wide RAM with 3-channel write port and 4-byte combinational read port). On a start pulse it accepts ROW_LEN 24-bit PE results (3 channels packed) and writes them into the buffer at channel strides 0 / ROW_LEN / 2·ROW_LEN. It then drains the 3·ROW_LEN bytes as 32-bit beats on a valid/ready stream toward the AXI-DMA S2MM path. It owns `ce`, `we`, `addr` and `d` of the buffer and is the only master of it.

---
 rtl/ofm_buf_ctrl_if.sv | 25 ++
 rtl/ofm_buf_ctrl.sv | 93 +++++++++
 tb/tb_ofm_buf_ctrl.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ofm_buf_ctrl_if.sv
// Stream and buffer-port bundle for the OFM stripe buffer sequencer.
// master = controller side, slave = PE source / buffer / DMA sink side.
interface ofm_buf_ctrl_if;
  logic        in_valid;
  logic [23:0] in_data;
  logic        in_ready;
  logic        buf_ce;
  logic        buf_we;
  logic [11:0] buf_addr;
  logic [23:0] buf_d;
  logic [31:0] buf_q;
  logic        m_valid;
  logic [31:0] m_data;
  logic        m_last;
  logic        m_ready;

  modport master (
    input  in_valid, in_data, buf_q, m_ready,
    output in_ready, buf_ce, buf_we, buf_addr, buf_d, m_valid, m_data, m_last
  );
  modport slave (
    output in_valid, in_data, buf_q, m_ready,
    input  in_ready, buf_ce, buf_we, buf_addr, buf_d, m_valid, m_data, m_last
  );
endinterface

// File: rtl/ofm_buf_ctrl.sv
// OFM stripe buffer sequencer: writes ROW_LEN packed 3-channel PE results,
// then drains 3*ROW_LEN bytes as 32-bit beats on a valid/ready stream.
module ofm_buf_ctrl #(
  parameter int ROW_LEN = 48
) (
  input  logic clk,
  input  logic rstn,
  input  logic start,
  output logic busy,
  output logic done,
  ofm_buf_ctrl_if.master bus
);
  localparam logic [11:0] WR_END  = 12'(ROW_LEN - 1);
  localparam logic [11:0] RD_LAST = 12'(3 * ROW_LEN - 4);

  typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_t;

  state_t      state;
  logic [11:0] wr_cnt;
  logic [11:0] rd_addr;
  logic        in_ready_r, m_valid_r, m_last_r, busy_r, done_r;
  logic        wr_acc;

  // Handshake outputs are registered alongside the state so no input
  // reaches them combinationally.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      wr_cnt     <= '0;
      rd_addr    <= '0;
      in_ready_r <= 1'b0;
      m_valid_r  <= 1'b0;
      m_last_r   <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state      <= WRITE;
          wr_cnt     <= '0;
          busy_r     <= 1'b1;
          in_ready_r <= 1'b1;
        end
        WRITE: if (bus.in_valid) begin
          wr_cnt <= wr_cnt + 12'd1;
          if (wr_cnt == WR_END) begin
            state      <= READ;
            rd_addr    <= '0;
            in_ready_r <= 1'b0;
            m_valid_r  <= 1'b1;
            m_last_r   <= (RD_LAST == 12'd0);
          end
        end
        READ: if (bus.m_ready) begin
          rd_addr  <= rd_addr + 12'd4;
          m_last_r <= (rd_addr + 12'd4 == RD_LAST);
          if (m_last_r) begin
            state     <= DONE;
            m_valid_r <= 1'b0;
            m_last_r  <= 1'b0;
            done_r    <= 1'b1;
          end
        end
        default: begin
          state  <= IDLE;
          busy_r <= 1'b0;
        end
      endcase
    end
  end

  assign wr_acc = in_ready_r & bus.in_valid;

  // Buffer port: write strobes follow in_valid directly; reads are
  // combinational, so m_data is simply the RAM output at rd_addr.
  always_comb begin
    bus.buf_ce   = wr_acc | m_valid_r;
    bus.buf_we   = wr_acc;
    bus.buf_addr = '0;
    bus.buf_d    = '0;
    if (m_valid_r)       bus.buf_addr = rd_addr;
    else if (in_ready_r) bus.buf_addr = wr_cnt;
    if (wr_acc)          bus.buf_d    = bus.in_data;
  end

  assign bus.in_ready = in_ready_r;
  assign bus.m_valid  = m_valid_r;
  assign bus.m_last   = m_last_r;
  assign bus.m_data   = bus.buf_q;
  assign busy         = busy_r;
  assign done         = done_r;
endmodule

// File: tb/tb_ofm_buf_ctrl.sv
// Bench for ofm_buf_ctrl: ROW_LEN=48 and ROW_LEN=8 instances share stream
// inputs; the byte-wide buffer is modelled here and beats are predicted from inputs.
module tb_ofm_buf_ctrl;
  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        start0 = 1'b0, start8 = 1'b0;
  logic        busy0, done0, busy8, done8;
  logic        in_valid = 1'b0;
  logic [23:0] in_data = '0;
  logic        m_ready = 1'b0;
  logic        cur_sel = 1'b0;
  int          n_tests = 0, n_fail = 0;

  always #5 clk = ~clk;

  ofm_buf_ctrl_if bus0();
  ofm_buf_ctrl_if bus8();

  ofm_buf_ctrl #(.ROW_LEN(48)) dut0 (.clk(clk), .rstn(rstn), .start(start0),
                                     .busy(busy0), .done(done0), .bus(bus0));
  ofm_buf_ctrl #(.ROW_LEN(8))  dut8 (.clk(clk), .rstn(rstn), .start(start8),
                                     .busy(busy8), .done(done8), .bus(bus8));

  assign bus0.in_valid = in_valid;
  assign bus0.in_data  = in_data;
  assign bus0.m_ready  = m_ready;
  assign bus8.in_valid = in_valid;
  assign bus8.in_data  = in_data;
  assign bus8.m_ready  = m_ready;

  // Buffer models: 3-channel write at strides 0/L/2L, big-endian 4-byte read
  logic [7:0] mem0 [0:4199];
  logic [7:0] mem8 [0:4199];
  int a0, a8;
  always_comb a0 = int'(bus0.buf_addr);
  always_comb a8 = int'(bus8.buf_addr);
  always @(posedge clk) begin
    if (bus0.buf_ce && bus0.buf_we) begin
      mem0[a0]      <= bus0.buf_d[23:16];
      mem0[a0 + 48] <= bus0.buf_d[15:8];
      mem0[a0 + 96] <= bus0.buf_d[7:0];
    end
    if (bus8.buf_ce && bus8.buf_we) begin
      mem8[a8]      <= bus8.buf_d[23:16];
      mem8[a8 + 8]  <= bus8.buf_d[15:8];
      mem8[a8 + 16] <= bus8.buf_d[7:0];
    end
  end
  assign bus0.buf_q = {mem0[a0], mem0[a0 + 1], mem0[a0 + 2], mem0[a0 + 3]};
  assign bus8.buf_q = {mem8[a8], mem8[a8 + 1], mem8[a8 + 2], mem8[a8 + 3]};

  logic        o_busy, o_done, o_in_ready, o_ce, o_we, o_mvalid, o_mlast;
  logic [11:0] o_addr;
  logic [23:0] o_d;
  logic [31:0] o_mdata;
  always_comb begin
    o_busy = cur_sel ? busy8 : busy0;
    o_done = cur_sel ? done8 : done0;
    o_in_ready = cur_sel ? bus8.in_ready : bus0.in_ready;
    o_ce = cur_sel ? bus8.buf_ce : bus0.buf_ce;
    o_we = cur_sel ? bus8.buf_we : bus0.buf_we;
    o_addr = cur_sel ? bus8.buf_addr : bus0.buf_addr;
    o_d = cur_sel ? bus8.buf_d : bus0.buf_d;
    o_mvalid = cur_sel ? bus8.m_valid : bus0.m_valid;
    o_mdata = cur_sel ? bus8.m_data : bus0.m_data;
    o_mlast = cur_sel ? bus8.m_last : bus0.m_last;
  end

  logic [42:0] outs0, outs8;
  assign outs0 = {busy0, done0, bus0.in_ready, bus0.m_valid, bus0.m_last, bus0.buf_ce,
                  bus0.buf_we, bus0.buf_addr, bus0.buf_d};
  assign outs8 = {busy8, done8, bus8.in_ready, bus8.m_valid, bus8.m_last, bus8.buf_ce,
                  bus8.buf_we, bus8.buf_addr, bus8.buf_d};

  typedef struct {
    int beats, writes, bad_wr, bad_data, bad_hold, done_cnt, done_cyc;
    bit busy_at_done, busy_after;
  } res_t;

  // One pass: start, feed ROW_LEN results, sink beats. Per-cycle discrepancies
  // against the reference byte-stream model are tallied into the result.
  task automatic run_pass(input bit sel, input bit pat, input bit gaps, input int rdy_pct,
                          input bit poke, input int stop_at, output res_t r);
    int          len, nb, n, c, kk;
    logic [23:0] vals [48];
    logic [31:0] exp_beat, prev_data;
    bit          prev_last, prev_stall, tog, p1, p2;
    len = sel ? 8 : 48;
    nb = 3 * len / 4;
    r = '{0, 0, 0, 0, 0, 0, -1, 1'b0, 1'b1};
    prev_stall = 0; prev_data = '0; prev_last = 0; tog = 1; p1 = 0; p2 = 0;
    for (int k = 0; k < 48; k++)
      vals[k] = pat ? {8'(k), 8'(k + 'h40), 8'(k + 'h80)} : 24'($urandom);
    cur_sel = sel;
    @(posedge clk); #1;
    if (sel) start8 = 1'b1; else start0 = 1'b1;
    @(posedge clk); #1;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      if (cyc > 0) begin @(posedge clk); #1; end
      start0 = 1'b0; start8 = 1'b0;
      in_valid = (r.writes < len) && (!gaps || tog);
      tog = ~tog;
      in_data = in_valid ? vals[r.writes] : 24'($urandom);
      m_ready = ($urandom_range(0, 99) < rdy_pct);
      if (poke && ((r.writes == 10 && !p1) || (r.beats == nb / 2 && !p2))) begin
        if (r.writes == 10) p1 = 1; else p2 = 1;
        if (sel) start8 = 1'b1; else start0 = 1'b1;
      end
      #1;
      if (o_in_ready && in_valid) begin
        if (!o_ce || !o_we || int'(o_addr) != r.writes || o_d !== vals[r.writes]) r.bad_wr++;
        r.writes++;
      end else if (o_in_ready && o_ce) r.bad_wr++;
      if (o_mvalid) begin
        if (prev_stall && (o_mdata !== prev_data || o_mlast !== prev_last)) r.bad_hold++;
        if (int'(o_addr) != 4 * r.beats || !o_ce || o_we) r.bad_data++;
        if (m_ready) begin
          exp_beat = '0;
          for (int i = 0; i < 4; i++) begin
            n = 4 * r.beats + i; c = n / len; kk = n % len;
            exp_beat = {exp_beat[23:0], 8'(vals[kk] >> (8 * (2 - c)))};
          end
          if (o_mdata !== exp_beat || o_mlast !== (r.beats == nb - 1)) begin
            r.bad_data++;
            $display("[TB] beat %0d: got %h/%b want %h/%b", r.beats, o_mdata, o_mlast,
                     exp_beat, r.beats == nb - 1);
          end
          r.beats++;
        end
        prev_stall = !m_ready; prev_data = o_mdata; prev_last = o_mlast;
      end else prev_stall = 0;
      if (r.done_cyc >= 0 && cyc == r.done_cyc + 1) r.busy_after = o_busy;
      if (o_done) begin
        r.done_cnt++;
        if (r.done_cyc < 0) begin r.done_cyc = cyc; r.busy_at_done = o_busy; end
      end
      if (stop_at >= 0 && r.beats == stop_at) begin in_valid = 0; m_ready = 0; return; end
      if (r.done_cyc >= 0 && cyc >= r.done_cyc + 3) break;
    end
    in_valid = 0; m_ready = 0;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'($urandom); in_data = 24'($urandom); m_ready = 1'($urandom);
      start0 = 1'($urandom); start8 = 1'($urandom);
      @(posedge clk); #1;
      n_tests++;
      if (outs0 !== '0 || outs8 !== '0) begin
        n_fail++; $display("FAIL reset_outputs: got %h/%h want 0", outs0, outs8);
      end
    end
    start0 = 0; start8 = 0;
    rstn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'($urandom); in_data = 24'($urandom); m_ready = 1'($urandom);
      @(posedge clk); #1;
      n_tests++;
      if ({busy0, bus0.in_ready, bus0.m_valid, bus0.buf_ce,
           busy8, bus8.in_ready, bus8.m_valid, bus8.buf_ce} !== '0) begin
        n_fail++; $display("FAIL idle_no_start: busy %b/%b ce %b/%b want 0",
                           busy0, busy8, bus0.buf_ce, bus8.buf_ce);
      end
    end
    in_valid = 0; m_ready = 0;
  endtask

  task automatic test_basic();
    res_t r;
    run_pass(1'b0, 1'b1, 1'b0, 100, 1'b0, -1, r);
    n_tests++; if (r.beats != 36) begin n_fail++; $display("FAIL basic_beats: got %0d want 36", r.beats); end
    n_tests++; if (r.writes != 48) begin n_fail++; $display("FAIL basic_writes: got %0d want 48", r.writes); end
    n_tests++; if (r.bad_wr != 0) begin n_fail++; $display("FAIL basic_wr_port: got %0d bad want 0", r.bad_wr); end
    n_tests++; if (r.bad_data != 0) begin n_fail++; $display("FAIL basic_data: got %0d bad want 0", r.bad_data); end
    n_tests++; if (r.done_cnt != 1) begin n_fail++; $display("FAIL basic_done_cnt: got %0d want 1", r.done_cnt); end
    n_tests++; if (r.done_cyc != 84) begin n_fail++; $display("FAIL basic_latency: got %0d want 84", r.done_cyc); end
    n_tests++;
    if (r.busy_at_done !== 1'b1 || r.busy_after !== 1'b0) begin
      n_fail++; $display("FAIL basic_busy_fall: got %b%b want 10", r.busy_at_done, r.busy_after);
    end
  endtask

  task automatic test_backpressure();
    res_t r;
    run_pass(1'b0, 1'b0, 1'b1, 50, 1'b0, -1, r);
    n_tests++; if (r.beats != 36) begin n_fail++; $display("FAIL bp_beats: got %0d want 36", r.beats); end
    n_tests++; if (r.bad_wr != 0) begin n_fail++; $display("FAIL bp_wr_port: got %0d bad want 0", r.bad_wr); end
    n_tests++; if (r.bad_data != 0) begin n_fail++; $display("FAIL bp_data: got %0d bad want 0", r.bad_data); end
    n_tests++; if (r.bad_hold != 0) begin n_fail++; $display("FAIL bp_hold: got %0d bad want 0", r.bad_hold); end
    n_tests++; if (r.done_cnt != 1) begin n_fail++; $display("FAIL bp_done_cnt: got %0d want 1", r.done_cnt); end
  endtask

  task automatic test_start_ignored();
    res_t r;
    run_pass(1'b0, 1'b0, 1'b0, 100, 1'b1, -1, r);
    n_tests++; if (r.done_cnt != 1) begin n_fail++; $display("FAIL poke_done_cnt: got %0d want 1", r.done_cnt); end
    n_tests++; if (r.beats != 36 || r.writes != 48) begin
      n_fail++; $display("FAIL poke_counts: got %0d/%0d want 36/48", r.beats, r.writes); end
    n_tests++; if (r.done_cyc != 84) begin n_fail++; $display("FAIL poke_latency: got %0d want 84", r.done_cyc); end
    n_tests++; if (busy0 !== 1'b0) begin n_fail++; $display("FAIL poke_no_requeue: busy got %b want 0", busy0); end
  endtask

  task automatic test_reset_mid_read();
    res_t r;
    run_pass(1'b0, 1'b0, 1'b0, 70, 1'b0, 20, r);
    n_tests++; if (r.beats != 20 || r.bad_data != 0) begin
      n_fail++; $display("FAIL abort_prefix: got %0d beats %0d bad want 20/0", r.beats, r.bad_data); end
    rstn = 1'b0;
    #1;
    n_tests++; if (outs0 !== '0) begin n_fail++; $display("FAIL abort_outputs: got %h want 0", outs0); end
    @(posedge clk); #1;
    rstn = 1'b1;
    n_tests++; if (done0 !== 1'b0) begin n_fail++; $display("FAIL abort_no_done: got %b want 0", done0); end
    run_pass(1'b0, 1'b0, 1'b0, 100, 1'b0, -1, r);
    n_tests++; if (r.beats != 36 || r.bad_data != 0 || r.bad_wr != 0) begin
      n_fail++; $display("FAIL abort_repass: got %0d beats %0d/%0d bad want 36/0/0", r.beats, r.bad_data, r.bad_wr); end
    n_tests++; if (r.done_cnt != 1) begin n_fail++; $display("FAIL abort_repass_done: got %0d want 1", r.done_cnt); end
  endtask

  task automatic test_row8();
    res_t r;
    run_pass(1'b1, 1'b1, 1'b0, 100, 1'b0, -1, r);
    n_tests++; if (r.beats != 6 || r.writes != 8) begin
      n_fail++; $display("FAIL row8_counts: got %0d/%0d want 6/8", r.beats, r.writes); end
    n_tests++; if (r.bad_data != 0 || r.bad_wr != 0) begin
      n_fail++; $display("FAIL row8_data: got %0d/%0d bad want 0/0", r.bad_data, r.bad_wr); end
    n_tests++; if (r.done_cyc != 14) begin n_fail++; $display("FAIL row8_latency: got %0d want 14", r.done_cyc); end
    run_pass(1'b1, 1'b0, 1'b1, 60, 1'b0, -1, r);
    n_tests++; if (r.beats != 6 || r.bad_data != 0 || r.bad_hold != 0 || r.bad_wr != 0) begin
      n_fail++; $display("FAIL row8_bp: got %0d beats %0d/%0d/%0d bad want 6/0/0/0",
                         r.beats, r.bad_data, r.bad_hold, r.bad_wr); end
    n_tests++; if (r.done_cnt != 1) begin n_fail++; $display("FAIL row8_done_cnt: got %0d want 1", r.done_cnt); end
    cur_sel = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_start_ignored();
    test_reset_mid_read();
    test_row8();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
